shift_right_iter: RTL and testbench
===================================

SHIFT_RIGHT_ITER -- requirements
Module: shift_right_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data width in bits.
REQ-002 SHALL have parameter CNTW, default 6, the shift-counter width; it is sized to hold the value WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: request a shift; sampled only while busy=0.
REQ-006 SHALL have port arith, input, 1 bit: 1 = arithmetic (sign-fill), 0 = logical (zero-fill); sampled with start.
REQ-007 SHALL have port a, input, WIDTH bits: the operand; sampled with start.
REQ-008 SHALL have port shamt, input, 32 bits: the unsigned shift amount; sampled with start.
REQ-009 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-011 SHALL have port result, output, WIDTH bits: the shifted value.

Function
REQ-012 SHALL implement three states: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 SHALL, at the next edge, load a into the working register, latch arith, set the counter to min(shamt, WIDTH), and go to SHIFT.
REQ-014 SHIFT SHALL, each cycle while counter != 0, shift the working register right by 1 bit, fill the MSB with (arith ? current MSB : 0), and decrement the counter.
REQ-015 SHIFT with counter == 0 SHALL go to DONE without shifting.
REQ-016 DONE SHALL assert done for exactly one cycle, copy the working register to result, and return to IDLE.
REQ-017 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-018 Latency: with start sampled at edge t, done SHALL be high during the cycle after edge t+1+n, where n = min(shamt, WIDTH); total cycles = n+2.
REQ-019 A shamt of WIDTH or more SHALL give all zeros (logical) or WIDTH copies of a[WIDTH-1] (arithmetic).
REQ-020 A shamt of 0 SHALL give result = a, with done after 2 cycles.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-022 result SHALL hold its value from the DONE cycle until the next DONE; it SHALL not change during SHIFT.
REQ-023 start asserted in the same cycle that done pulses SHALL be ignored (busy=1); a new start is accepted the cycle after.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, result=0, counter=0, and the working register to 0.
REQ-025 Reset asserted mid-operation SHALL abort it with no done pulse; after release the block SHALL accept start on the first rising edge.

Structure
REQ-026 The state encoding (IDLE/SHIFT/DONE enum) and the default WIDTH constant SHALL live in the shared package shift_pkg.
REQ-027 The shamt clamp (min(shamt, WIDTH) to CNTW bits) SHALL be the sub-module shift_amt_clamp; everything else SHALL be flat.

Verification
REQ-028 a=0x80000000, shamt=2, arith=0 -> result 0x20000000; done 4 cycles after the start edge.
REQ-029 a=0xFFFFFFFF, shamt=1, arith=1 -> 0xFFFFFFFF; the same stimulus with arith=0 -> 0x7FFFFFFF.
REQ-030 a=0x80000001, shamt=40, arith=0 -> 0x00000000 after 34 cycles; with arith=1 -> 0xFFFFFFFF.
REQ-031 a=0x12345678, shamt=0 -> result 0x12345678 after 2 cycles.
REQ-032 start a=0xF0, shamt=4, then start a=0x1, shamt=0 while busy -> only result 0x0F with a single done pulse; rst_n pulsed low mid-SHIFT -> busy=0 and result=0 immediately, with no done pulse.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state encoding and default width for the iterative right shifter
package shift_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_amt_clamp.sv
// rtl/shift_amt_clamp.sv - clamps a 32-bit shift amount to min(shamt, WIDTH) on CNTW bits
module shift_amt_clamp #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic [31:0]     shamt,
  output logic [CNTW-1:0] cnt
);

  // Anything past WIDTH already empties the word, so WIDTH steps are enough.
  always_comb begin
    if (shamt >= 32'(WIDTH)) cnt = CNTW'(WIDTH);
    else                     cnt = shamt[CNTW-1:0];
  end

endmodule

// File: rtl/shift_right_iter.sv
// rtl/shift_right_iter.sv - one-bit-per-cycle logical/arithmetic right shifter
module shift_right_iter
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] a,
  input  logic [31:0]      shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [CNTW-1:0]  cnt;
  logic [CNTW-1:0]  cnt_init;
  logic             arith_q;

  shift_amt_clamp #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_clamp (
    .shamt (shamt),
    .cnt   (cnt_init)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      work    <= '0;
      cnt     <= '0;
      arith_q <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work    <= a;
            arith_q <= arith;
            cnt     <= cnt_init;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            work <= {(arith_q & work[WIDTH-1]), work[WIDTH-1:1]};
            cnt  <= cnt - CNTW'(1);
          end else begin
            // result is loaded on entry to DONE so it is valid while done is high
            result <= work;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_right_iter.sv
// tb/tb_shift_right_iter.sv - directed self-checking bench for shift_right_iter
module tb_shift_right_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        arith;
  logic [31:0] a;
  logic [31:0] shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int failures;

  shift_right_iter #(
    .WIDTH (32),
    .CNTW  (6)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .arith  (arith),
    .a      (a),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation, then checks result, latency, result stability and the single done pulse.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tsh,
                        input logic tar, input logic [31:0] exp_res, input int exp_lat);
    int          lat;
    logic [31:0] prev;
    bit          changed;
    prev    = result;
    changed = 1'b0;
    a       = ta;
    shamt   = tsh;
    arith   = tar;
    start   = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (1) begin
      lat++;
      if (done || lat >= 100) break;
      if (result !== prev) changed = 1'b1;
      tick();
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_stable"}, 32'(changed), 32'd0);
    tick();
    check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int n_done;
    int guard;
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    arith    = 1'b0;
    a        = '0;
    shamt    = '0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    run_op("lsr_msb_by2",   32'h8000_0000, 32'd2,  1'b0, 32'h2000_0000, 4);
    run_op("asr_ones_by1",  32'hFFFF_FFFF, 32'd1,  1'b1, 32'hFFFF_FFFF, 3);
    run_op("lsr_ones_by1",  32'hFFFF_FFFF, 32'd1,  1'b0, 32'h7FFF_FFFF, 3);
    run_op("lsr_by40",      32'h8000_0001, 32'd40, 1'b0, 32'h0000_0000, 34);
    run_op("asr_by40",      32'h8000_0001, 32'd40, 1'b1, 32'hFFFF_FFFF, 34);
    run_op("asr_by32",      32'h4000_0000, 32'd32, 1'b1, 32'h0000_0000, 34);
    run_op("asr_neg_by31",  32'h8000_0000, 32'd31, 1'b1, 32'hFFFF_FFFF, 33);
    run_op("shamt_zero",    32'h1234_5678, 32'd0,  1'b0, 32'h1234_5678, 2);
    run_op("asr_pos_by4",   32'h7000_00F0, 32'd4,  1'b1, 32'h0700_000F, 6);
    run_op("huge_shamt",    32'hC000_0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 34);

    // Second start while busy must not disturb the operation in flight.
    a = 32'h0000_00F0; shamt = 32'd4; arith = 1'b0; start = 1'b1;
    tick();
    a = 32'h0000_0001; shamt = 32'd0; arith = 1'b1;
    tick();
    start  = 1'b0;
    n_done = 0;
    guard  = 0;
    while (busy && guard < 100) begin
      if (done) begin
        n_done++;
        check("busy_start_result", result, 32'h0000_000F);
      end
      guard++;
      tick();
    end
    check("busy_start_pulses", 32'(n_done), 32'd1);
    check("busy_start_final", result, 32'h0000_000F);

    // Start raised during the done cycle is ignored; accepted one cycle later.
    a = 32'h0000_FF00; shamt = 32'd8; arith = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!done && guard < 100) begin
      guard++;
      tick();
    end
    check("done_cycle_seen", 32'(done), 32'd1);
    check("done_cycle_result", result, 32'h0000_00FF);
    a = 32'h0000_AAAA; shamt = 32'd0; start = 1'b1;
    tick();
    check("start_in_done_ignored", 32'(busy), 32'd0);
    tick();
    check("start_after_done_taken", 32'(busy), 32'd1);
    start = 1'b0;
    tick();
    check("start_after_done_pulse", 32'(done), 32'd1);
    check("start_after_done_result", result, 32'h0000_AAAA);
    tick();

    // Reset in the middle of SHIFT aborts with no done pulse.
    a = 32'hFFFF_FFFF; shamt = 32'd10; arith = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_result", result, 32'd0);
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) n_done++;
      tick();
    end
    check("midreset_no_done", 32'(n_done), 32'd0);
    rst_n = 1'b1;
    run_op("after_reset", 32'h0000_0010, 32'd4, 1'b0, 32'h0000_0001, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
